// File: rtl/tmc_nios2_irq_ctrl_pkg.sv
// Shared definitions for the Nios II interrupt controller: register map,
// source limit and the coalescing state encoding.
package tmc_irq_pkg;

    localparam int MAX_SRC = 8;

    localparam logic [2:0] ADDR_STATUS       = 3'd0;
    localparam logic [2:0] ADDR_MASK         = 3'd1;
    localparam logic [2:0] ADDR_MODE         = 3'd2;
    localparam logic [2:0] ADDR_VECTOR       = 3'd3;
    localparam logic [2:0] ADDR_COAL_THRESH  = 3'd4;
    localparam logic [2:0] ADDR_COAL_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } coal_state_t;

endpackage

// File: rtl/tmc_nios2_irq_ctrl_if.sv
// Avalon-MM slave register port of the interrupt controller.
interface tmc_nios2_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tmc_nios2_irq_ctrl_sync.sv
// Per-source 2-flop synchronizer with rising-edge detector. The history
// flop resets to 0 so a source held high through reset reads as an edge.
module tmc_irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic sync,
    output logic rise
);
    logic meta;
    logic sync_q;
    logic prev;

    // Two synchronizer stages plus one history stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= d;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev;
endmodule

// File: rtl/tmc_nios2_irq_ctrl.sv
// Nios II interrupt controller: per-source pending latch (edge or level),
// mask, lowest-index vector and a registered aggregate irq.
// Defining TMC_IRQ_COALESCE_EN adds threshold/timeout interrupt coalescing
// (registers 4-5 and an IDLE/ACCUM/FIRE state machine).
//
// state | meaning
// IDLE  | no coalescing window open, irq low
// ACCUM | counting masked events and cycles since the first event
// FIRE  | irq asserted until all masked pending bits are cleared
module tmc_nios2_irq_ctrl
    import tmc_irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tmc_nios2_irq_ctrl_if.slave  bus,
    input  logic [NUM_SRC-1:0]   irq_in,
    output logic                 irq
);
    logic [NUM_SRC-1:0] src_sync;
    logic [NUM_SRC-1:0] src_rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] pend_masked;
    logic               vec_valid;
    logic [2:0]         vec_idx;
    logic [15:0]        rd_mux;
    logic               wr;
    logic               unused_wdata;

    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        tmc_irq_sync u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (irq_in[i]),
            .sync    (src_sync[i]),
            .rise    (src_rise[i])
        );
    end

    assign wr          = bus.chipselect & ~bus.write_n;
    assign pend_masked = pending & mask;

    // Write-one-to-clear strobe for the STATUS register
    always_comb begin
        w1c = '0;
        if (wr && bus.address == ADDR_STATUS) w1c = bus.writedata[NUM_SRC-1:0];
    end

    // MASK and MODE registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            mode <= '0;
        end else if (wr) begin
            if (bus.address == ADDR_MASK) mask <= bus.writedata[NUM_SRC-1:0];
            if (bus.address == ADDR_MODE) mode <= bus.writedata[NUM_SRC-1:0];
        end
    end

    // Pending: edge sources latch rises (set beats clear), level sources follow input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= (mode & (src_rise | (pending & ~w1c))) | (~mode & src_sync);
    end

    // Lowest-index masked pending source
    always_comb begin
        vec_valid = |pend_masked;
        vec_idx   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) vec_idx = 3'(i);
        end
    end

`ifdef TMC_IRQ_COALESCE_EN
    logic [7:0]  coal_thresh;
    logic [15:0] coal_timeout;
    coal_state_t state, state_nxt;
    logic [7:0]  evt_cnt, evt_cnt_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic        evt;

    assign evt = |(src_rise & mask);

    // Coalescing configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coal_thresh  <= 8'd1;
            coal_timeout <= 16'd0;
        end else if (wr) begin
            if (bus.address == ADDR_COAL_THRESH)  coal_thresh  <= bus.writedata[7:0];
            if (bus.address == ADDR_COAL_TIMEOUT) coal_timeout <= bus.writedata;
        end
    end

    // Coalescing next-state and counter logic; timer counts the entry cycle as 1
    always_comb begin
        state_nxt   = state;
        evt_cnt_nxt = evt_cnt;
        tmr_nxt     = tmr;
        case (state)
            IDLE: begin
                evt_cnt_nxt = 8'd0;
                tmr_nxt     = 16'd0;
                if (evt) begin
                    state_nxt   = ACCUM;
                    evt_cnt_nxt = 8'd1;
                    tmr_nxt     = 16'd1;
                end
            end
            ACCUM: begin
                if (evt && evt_cnt != 8'hFF) evt_cnt_nxt = evt_cnt + 8'd1;
                tmr_nxt = tmr + 16'd1;
                if (evt_cnt >= coal_thresh || (coal_timeout != 16'd0 && tmr == coal_timeout))
                    state_nxt = FIRE;
            end
            FIRE: begin
                if (pend_masked == '0) begin
                    state_nxt   = IDLE;
                    evt_cnt_nxt = 8'd0;
                    tmr_nxt     = 16'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coalescing state, counters and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            evt_cnt <= 8'd0;
            tmr     <= 16'd0;
            irq     <= 1'b0;
        end else begin
            state   <= state_nxt;
            evt_cnt <= evt_cnt_nxt;
            tmr     <= tmr_nxt;
            irq     <= (state_nxt == FIRE);
        end
    end
`else
    // Registered aggregate interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |pend_masked;
    end
`endif

    // Read data multiplexer
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_STATUS: rd_mux[NUM_SRC-1:0] = pending;
            ADDR_MASK:   rd_mux[NUM_SRC-1:0] = mask;
            ADDR_MODE:   rd_mux[NUM_SRC-1:0] = mode;
            ADDR_VECTOR: begin
                rd_mux[15]  = vec_valid;
                rd_mux[2:0] = vec_idx;
            end
`ifdef TMC_IRQ_COALESCE_EN
            ADDR_COAL_THRESH:  rd_mux[7:0] = coal_thresh;
            ADDR_COAL_TIMEOUT: rd_mux      = coal_timeout;
`endif
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated whenever the slave is selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            bus.readdata <= '0;
        else if (bus.chipselect) bus.readdata <= rd_mux;
    end
endmodule
